// File: rtl/adc_seq_arb.sv
// adc_seq_arb: round-robin two-client arbiter and req/rdy handshake sequencer for a shared ADC
module adc_seq_arb #(
   parameter int DW         = 8,
   parameter int TIMEOUT    = 15,
   parameter int RST_CYCLES = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req0,
   input  logic          req1,
   output logic          ack0,
   output logic          ack1,
   output logic [DW-1:0] dout,
   output logic          adc_req,
   output logic          adc_rst,
   input  logic          adc_rdy,
   input  logic [DW-1:0] adc_dat,
   output logic          busy,
   output logic          owner,
   output logic          err,
   input  logic          clr_err
);
   typedef enum logic [2:0] {INIT, IDLE, REQ, DONE, RECOVER} state_t;
   localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);
   localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);
   state_t        state_q, state_d;
   logic [7:0]    rst_cnt_q, rst_cnt_d, timer_q, timer_d;
   logic [DW-1:0] dout_q, dout_d;
   logic          ack0_q, ack0_d, ack1_q, ack1_d, adc_req_q, adc_req_d, adc_rst_q, adc_rst_d;
   logic          busy_q, busy_d, owner_q, owner_d, err_q, err_d, timeout;
   always_comb begin
      state_d   = state_q;
      rst_cnt_d = rst_cnt_q;
      timer_d   = timer_q;
      dout_d    = dout_q;
      ack0_d    = 1'b0;
      ack1_d    = 1'b0;
      adc_req_d = adc_req_q;
      adc_rst_d = adc_rst_q;
      owner_d   = owner_q;
      timeout   = 1'b0;
      case (state_q)
         INIT, RECOVER: begin
            rst_cnt_d = (rst_cnt_q == RST_LAST) ? 8'd0 : rst_cnt_q + 8'd1;
            adc_rst_d = rst_cnt_q != RST_LAST;
            state_d   = (rst_cnt_q == RST_LAST) ? IDLE : state_q;
         end
         IDLE: if (req0 || req1) begin
            // contention goes to whoever was not served last
            owner_d   = (req0 && req1) ? ~owner_q : req1;
            state_d   = REQ;
            adc_req_d = 1'b1;
            timer_d   = 8'd0;
         end
         REQ: if (adc_rdy) begin
            dout_d    = adc_dat;
            ack0_d    = ~owner_q;
            ack1_d    = owner_q;
            adc_req_d = 1'b0;
            state_d   = DONE;
            timer_d   = 8'd0;
         end else begin
            timeout = timer_q == TO_LAST;
            timer_d = timer_q + 8'd1;
         end
         DONE: if (!adc_rdy) state_d = IDLE;
         else begin
            timeout = timer_q == TO_LAST;
            timer_d = timer_q + 8'd1;
         end
         default: state_d = INIT;
      endcase
      if (timeout) begin
         state_d   = RECOVER;
         adc_req_d = 1'b0;
         adc_rst_d = 1'b1;
         rst_cnt_d = 8'd0;
         timer_d   = 8'd0;
      end
      err_d  = timeout | (err_q & ~clr_err);
      busy_d = state_d != IDLE;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= INIT;
         rst_cnt_q <= 8'd0;
         timer_q   <= 8'd0;
         dout_q    <= '0;
         ack0_q    <= 1'b0;
         ack1_q    <= 1'b0;
         adc_req_q <= 1'b0;
         adc_rst_q <= 1'b1;
         busy_q    <= 1'b1;
         owner_q   <= 1'b1;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         rst_cnt_q <= rst_cnt_d;
         timer_q   <= timer_d;
         dout_q    <= dout_d;
         ack0_q    <= ack0_d;
         ack1_q    <= ack1_d;
         adc_req_q <= adc_req_d;
         adc_rst_q <= adc_rst_d;
         busy_q    <= busy_d;
         owner_q   <= owner_d;
         err_q     <= err_d;
      end
   end
   assign ack0    = ack0_q;
   assign ack1    = ack1_q;
   assign dout    = dout_q;
   assign adc_req = adc_req_q;
   assign adc_rst = adc_rst_q;
   assign busy    = busy_q;
   assign owner   = owner_q;
   assign err     = err_q;
endmodule

// File: tb/tb_adc_seq_arb.sv
// tb_adc_seq_arb: directed bench for adc_seq_arb with a simple responsive ADC model
module tb_adc_seq_arb;
   logic       clk, reset, req0, req1, ack0, ack1, adc_req, adc_rst, adc_rdy;
   logic       busy, owner, err, clr_err;
   logic [7:0] dout, adc_dat;
   logic       adc_on, prev_req;
   int         hold_extra, hold, checks, errors, ack0_cnt, ack1_cnt, a0, a1;
   adc_seq_arb dut (
      .clk(clk), .reset(reset), .req0(req0), .req1(req1), .ack0(ack0), .ack1(ack1),
      .dout(dout), .adc_req(adc_req), .adc_rst(adc_rst), .adc_rdy(adc_rdy),
      .adc_dat(adc_dat), .busy(busy), .owner(owner), .err(err), .clr_err(clr_err)
   );
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask
   // ADC answers one cycle after seeing adc_req, optionally holding rdy hold_extra cycles longer
   initial begin
      adc_rdy  = 1'b0;
      prev_req = 1'b0;
      hold     = 0;
      forever begin
         @(negedge clk);
         if (!adc_on) adc_rdy = 1'b0;
         else if (prev_req) begin
            adc_rdy = 1'b1;
            hold    = hold_extra;
         end else if (hold > 0) begin
            hold--;
            adc_rdy = 1'b1;
         end else adc_rdy = 1'b0;
         prev_req = adc_req;
      end
   end
   initial begin
      forever begin
         @(posedge clk);
         #1;
         ack0_cnt += int'(ack0);
         ack1_cnt += int'(ack1);
         chk("ack_excl", ack0 & ack1, 0);
         chk("req_rst_excl", adc_req & adc_rst, 0);
      end
   end
   task automatic serve(input logic who, input logic [7:0] d, input logic again, input logic [7:0] nd);
      for (int n = 0; n < 40 && !(ack0 || ack1); n++) @(negedge clk);
      if (!(ack0 || ack1)) @(negedge clk);
      chk("ack_seen", ack0 | ack1, 1);
      chk("ack0_sel", ack0, !who);
      chk("ack1_sel", ack1, who);
      chk("dout", dout, d);
      chk("owner", owner, who);
      if (who) req1 = 1'b0; else req0 = 1'b0;
      if (!again) begin
         req0 = 1'b0;
         req1 = 1'b0;
      end
      adc_dat = nd;
      @(negedge clk);
      chk("ack_pulse", ack0 | ack1, 0);
      if (again) begin
         if (who) req1 = 1'b1; else req0 = 1'b1;
      end
   endtask
   task automatic wait_idle();
      for (int n = 0; n < 40 && busy; n++) @(negedge clk);
      chk("idle_reached", busy, 0);
   endtask
   initial begin
      checks = 0; errors = 0; ack0_cnt = 0; ack1_cnt = 0;
      reset = 1'b0; req0 = 1'b0; req1 = 1'b0; clr_err = 1'b0;
      adc_on = 1'b1; hold_extra = 0; adc_dat = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 1);
      chk("rst_adc_rst", adc_rst, 1);
      chk("rst_adc_req", adc_req, 0);
      chk("rst_owner", owner, 1);
      chk("rst_err", err, 0);
      chk("rst_dout", dout, 0);
      chk("rst_acks", ack0 | ack1, 0);
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("init_adc_rst", adc_rst, 1);
      end
      @(negedge clk);
      chk("init_end_rst", adc_rst, 0);
      chk("init_idle", busy, 0);
      chk("init_dout", dout, 0);
      chk("init_err", err, 0);
      // contention: round-robin starting with client 0
      req0 = 1'b1; req1 = 1'b1; adc_dat = 8'h11;
      serve(1'b0, 8'h11, 1'b1, 8'h22);
      serve(1'b1, 8'h22, 1'b1, 8'h33);
      serve(1'b0, 8'h33, 1'b1, 8'h44);
      serve(1'b1, 8'h44, 1'b0, 8'h00);
      wait_idle();
      chk("rr_ack0_cnt", ack0_cnt, 2);
      chk("rr_ack1_cnt", ack1_cnt, 2);
      // single request latency
      a1 = ack1_cnt;
      req0 = 1'b1; adc_dat = 8'hD6;
      @(negedge clk);
      chk("lat_adc_req", adc_req, 1);
      chk("lat_owner", owner, 0);
      chk("lat_busy", busy, 1);
      @(negedge clk);
      chk("lat_no_ack_early", ack0, 0);
      @(negedge clk);
      chk("lat_ack0", ack0, 1);
      chk("lat_dout", dout, 8'hD6);
      chk("lat_req_drop", adc_req, 0);
      req0 = 1'b0;
      @(negedge clk);
      chk("lat_ack_pulse", ack0, 0);
      chk("lat_done_busy", busy, 1);
      @(negedge clk);
      chk("lat_idle", busy, 0);
      chk("lat_no_ack1", ack1_cnt, a1);
      // timeout and recovery
      adc_on = 1'b0; req1 = 1'b1;
      @(negedge clk);
      chk("to_adc_req", adc_req, 1);
      chk("to_owner", owner, 1);
      repeat (14) @(negedge clk);
      chk("to_err_pre", err, 0);
      chk("to_req_pre", adc_req, 1);
      @(negedge clk);
      chk("to_err", err, 1);
      chk("to_req_drop", adc_req, 0);
      chk("to_adc_rst", adc_rst, 1);
      repeat (3) @(negedge clk);
      chk("rec_adc_rst", adc_rst, 1);
      @(negedge clk);
      chk("rec_end_rst", adc_rst, 0);
      chk("rec_idle", busy, 0);
      chk("rec_no_ack", ack1_cnt, a1);
      adc_on = 1'b1; adc_dat = 8'h5A;
      serve(1'b1, 8'h5A, 1'b0, 8'h00);
      chk("err_sticky", err, 1);
      wait_idle();
      chk("err_sticky_idle", err, 1);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      chk("err_cleared", err, 0);
      // asynchronous abort mid-transaction
      adc_on = 1'b0; req0 = 1'b1; a0 = ack0_cnt;
      @(negedge clk);
      chk("abort_pre_req", adc_req, 1);
      #2 reset = 1'b0;
      #1;
      chk("abort_req", adc_req, 0);
      chk("abort_rst", adc_rst, 1);
      chk("abort_ack", ack0, 0);
      @(negedge clk);
      reset = 1'b1; adc_on = 1'b1; adc_dat = 8'h77;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("reinit_adc_rst", adc_rst, 1);
      end
      @(negedge clk);
      chk("reinit_end_rst", adc_rst, 0);
      chk("reinit_idle", busy, 0);
      chk("abort_no_ack", ack0_cnt, a0);
      serve(1'b0, 8'h77, 1'b0, 8'h00);
      wait_idle();
      // ADC keeps rdy high well past capture
      hold_extra = 6; req0 = 1'b1; adc_dat = 8'hA5; a0 = ack0_cnt;
      @(negedge clk);
      chk("hold_adc_req", adc_req, 1);
      @(negedge clk);
      @(negedge clk);
      chk("hold_ack0", ack0, 1);
      chk("hold_dout", dout, 8'hA5);
      req0 = 1'b0;
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         chk("hold_busy", busy, 1);
         chk("hold_no_ack", ack0, 0);
      end
      @(negedge clk);
      chk("hold_idle", busy, 0);
      chk("hold_one_ack", ack0_cnt, a0 + 1);
      hold_extra = 0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/adc_seq_arb.md
Name: adc_seq_arb

Overview:
Sequencer and arbiter for the shared 8-bit ADC. It owns the ADC req/rst/rdy/dat handshake and runs a power-up reset sequence. It arbitrates single-sample requests from two clients, port 0 (capture controller) and port 1 (housekeeping/monitor), using round-robin. It detects a stalled ADC by timeout and recovers by re-running the ADC reset.

Parameters:
DW, 8, ADC data width
TIMEOUT, 15, max cycles waiting on an adc_rdy edge before error (1..255)
RST_CYCLES, 4, cycles adc_rst is held high in init/recovery (1..255)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset; reset=0 forces reset state immediately
req0  in  1  client 0 sample request, level, held until ack0
req1  in  1  client 1 sample request, level, held until ack1
ack0  out  1  one-cycle pulse: sample for client 0 valid on dout
ack1  out  1  one-cycle pulse: sample for client 1 valid on dout
dout  out  DW  last captured sample, stable until next capture
adc_req  out  1  request to ADC
adc_rst  out  1  ADC reset, active high
adc_rdy  in  1  ADC ready/data-valid
adc_dat  in  DW  ADC data, valid while adc_rdy=1
busy  out  1  high in any state except IDLE
owner  out  1  client currently or last granted
err  out  1  sticky timeout flag
clr_err  in  1  synchronous clear of err

Behaviour:
- Reset (reset=0): state=INIT, rst_cnt=0, timer=0, adc_req=0, adc_rst=1, ack0=ack1=0, dout=0, owner=1 (client 0 wins the first contention), err=0, busy=1.
- All outputs are registered. adc_rdy and adc_dat are sampled on the rising edge (single-cycle sample; no synchroniser, ADC is in the same clock domain).
- INIT: adc_rst=1 for exactly RST_CYCLES cycles after reset release, then IDLE with adc_rst=0.
- IDLE: adc_req=0, busy=0.
  - Requests are sampled each edge.
  - Only one requester: grant it.
  - Both requesting: grant the client != owner.
  - On grant: owner<=granted client, state=REQ, adc_req=1 from the next cycle, timer=0.
- REQ: adc_req=1, timer increments each cycle.
  - adc_rdy=1 sampled: dout<=adc_dat, ack[owner] pulses high the next cycle, adc_req<=0, state=DONE, timer=0.
  - timer reaches TIMEOUT without adc_rdy: state=RECOVER, err<=1, adc_req<=0. No ack is given; the client keeps its request.
- DONE (four-phase completion): adc_req=0, waits for adc_rdy=0 sampled, then IDLE. Timeout applies as in REQ and leads to RECOVER.
- RECOVER: adc_rst=1 for RST_CYCLES cycles, then IDLE. The pending request is re-arbitrated normally.
- Latency, request to ack with an ADC answering in 1 cycle:
  - req at edge k
  - adc_req=1 after edge k
  - adc_rdy seen at edge k+2
  - ack after edge k+2
  - minimum 3 cycles request-to-ack.
- Throughput: IDLE is mandatory between transactions (one cycle minimum).
- A client deasserting req in REQ/DONE does not abort the transaction; the ack is still issued.
- A client must drop req the cycle after ack; if still high in IDLE it is treated as a new request.
- clr_err has priority over setting err in the same cycle only if no timeout occurs in that cycle; a simultaneous timeout sets err.
- reset=0 mid-transaction aborts immediately: adc_req=0, no ack, INIT sequence reruns.
- ack0 and ack1 are never high together. adc_req and adc_rst are never high together.

Test Plan:
- Reset release, no requests -> adc_rst=1 for exactly 4 cycles, then IDLE, busy=0, dout=0, err=0.
- req0 held, ADC model raises rdy 1 cycle after adc_req with dat=8'hD6, drops it after adc_req falls -> ack0 one pulse at edge k+2, dout=8'hD6, owner=0, ack1 never asserted.
- req0 and req1 asserted together and held, re-raised after each ack, for 4 transactions, ADC returning 8'h11/8'h22/8'h33/8'h44 -> grant order 0,1,0,1, each ack matched to its dout value.
- req1, ADC never raises rdy -> err=1 after 15 REQ cycles, adc_rst=1 for 4 cycles, no ack. Then ADC responds with 8'h5A -> ack1, dout=8'h5A, err stays 1 until clr_err pulse.
- reset pulsed low while in REQ -> adc_req falls asynchronously, no ack, INIT 4-cycle adc_rst sequence repeats, a held request is then served normally.
- ADC holds rdy high for 6 cycles after capture -> state stays DONE, busy=1, no second ack; IDLE one cycle after rdy drops.
